memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_byte_array.sv | 47 ++++
 rtl/memory_responder.sv | 131 +++++++++++++
 tb/tb_memory_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: Size encodings, FSM state
// constants and byte-lane helpers. Lane 0 is the byte at the base address,
// which is the most significant byte because storage is big-endian.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t DONE = 2'd2;

    // lane_en[3] is lane 0 (address A), lane_en[0] is lane 3 (address A+3)
    localparam logic [3:0] LANES_BYTE = 4'b1000;
    localparam logic [3:0] LANES_HALF = 4'b1100;
    localparam logic [3:0] LANES_WORD = 4'b1111;

    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_mask = LANES_BYTE;
            SZ_HALF: lane_mask = LANES_HALF;
            default: lane_mask = LANES_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lsb[0];
            default: misaligned = (addr_lsb != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with four lanes at addr..addr+3, wrapping modulo DEPTH.
// wdata/rdata are packed big-endian: bits [31:24] belong to address addr.
// The array has no reset; its contents survive reset_n.
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               lane_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] lane_addr [4];

    // Per-lane addresses; the AW-bit adder wraps naturally at DEPTH
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = addr + AW'(i);
        end
    end

    // Commit enabled lanes on a write strobe
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[3-i]) begin
                    mem[lane_addr[i]] <= wdata[31-8*i -: 8];
                end
            end
        end
    end

    // Asynchronous read of all four lanes
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            rdata[31-8*i -: 8] = mem[lane_addr[i]];
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Memory responder for a control unit using a MOV/MOC four-phase handshake.
// A request is latched in IDLE, waits WAIT_STATES extra cycles, then commits
// a write or loads DataOut on entry to DONE; MOC stays high until MOV falls.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned halfword
// and word accesses (no write, DataOut=0, Err=1 while MOC is high).
module memory_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MOV,
    input  logic        R_W,
    input  logic [1:0]  Size,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        Err
);
    localparam int AW = $clog2(DEPTH);

    state_t        state;
    logic [3:0]    cnt;
    logic          r_w_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;

    logic          finish;
    logic          bad;
    logic          mem_we;
    logic [31:0]   wdata_lanes;
    logic [31:0]   rdata_lanes;
    logic [31:0]   rd_ext;
    logic          unused_addr_hi;

    // Upper address bits are discarded: addressing is modulo DEPTH
    assign unused_addr_hi = ^Address[31:AW];

`ifdef MEM_ALIGN_CHECK_EN
    assign bad = misaligned(size_q, addr_q[1:0]);
`else
    assign bad = 1'b0;
`endif

    assign finish = (state == WAIT) && MOV && (cnt == 4'(WAIT_STATES));
    assign mem_we = finish && !r_w_q && !bad;
    assign MOC    = (state == DONE);

    // Place write data in the leading lanes and zero-extend read data
    always_comb begin
        case (size_q)
            SZ_BYTE: begin
                wdata_lanes = {data_q[7:0], 24'h0};
                rd_ext      = {24'h0, rdata_lanes[31:24]};
            end
            SZ_HALF: begin
                wdata_lanes = {data_q[15:0], 16'h0};
                rd_ext      = {16'h0, rdata_lanes[31:16]};
            end
            default: begin
                wdata_lanes = data_q;
                rd_ext      = rdata_lanes;
            end
        endcase
    end

    // Latch the request fields when a new operation is accepted
    always_ff @(posedge clk) begin
        if (state == IDLE && MOV) begin
            r_w_q  <= R_W;
            size_q <= Size;
            addr_q <= Address[AW-1:0];
            data_q <= DataIn;
        end
    end

    // Handshake FSM, wait counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            DataOut <= '0;
            Err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MOV) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (!MOV) begin
                        state <= IDLE;
                    end else if (finish) begin
                        state <= DONE;
                        Err   <= bad;
                        if (bad) begin
                            DataOut <= '0;
                        end else if (r_w_q) begin
                            DataOut <= rd_ext;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (!MOV) begin
                        state <= IDLE;
                        Err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_byte_array #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .lane_en (lane_mask(size_q)),
        .addr    (addr_q),
        .wdata   (wdata_lanes),
        .rdata   (rdata_lanes)
    );

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance with WAIT_STATES=2 and
// one with WAIT_STATES=0. Expected values are hand-computed constants.
module tb_memory_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        mov_a, rw_a, moc_a, err_a;
    logic [1:0]  size_a;
    logic [31:0] addr_a, din_a, dout_a;
    logic        mov_b, rw_b, moc_b, err_b;
    logic [1:0]  size_b;
    logic [31:0] addr_b, din_b, dout_b;

    memory_responder #(.DEPTH(256), .WAIT_STATES(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .MOV(mov_a), .R_W(rw_a), .Size(size_a),
        .Address(addr_a), .DataIn(din_a), .DataOut(dout_a), .MOC(moc_a), .Err(err_a)
    );

    memory_responder #(.DEPTH(256), .WAIT_STATES(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .MOV(mov_b), .R_W(rw_b), .Size(size_b),
        .Address(addr_b), .DataIn(din_b), .DataOut(dout_b), .MOC(moc_b), .Err(err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a request (called #1 after a rising edge) and wait for MOC.
    // lat = edges after the sampling edge until MOC is seen; -1 on timeout.
    task automatic start_wait(input bit sel, input logic rw, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] d, output int lat);
        if (!sel) begin
            mov_a = 1'b1; rw_a = rw; size_a = sz; addr_a = a; din_a = d;
        end else begin
            mov_b = 1'b1; rw_b = rw; size_b = sz; addr_b = a; din_b = d;
        end
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (sel ? moc_b : moc_a) begin
                lat = n;
                break;
            end
        end
    endtask

    // Full transaction: request, MOC, drop MOV, confirm MOC and Err clear
    task automatic run_op(input string tag, input bit sel, input logic rw, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] dout, output logic err);
        start_wait(sel, rw, sz, a, d, lat);
        dout = sel ? dout_b : dout_a;
        err  = sel ? err_b : err_a;
        if (!sel) mov_a = 1'b0; else mov_b = 1'b0;
        @(posedge clk); #1;
        check_val({tag, "_moc_low"}, {31'b0, sel ? moc_b : moc_a}, 32'h0);
        check_val({tag, "_err_low"}, {31'b0, sel ? err_b : err_a}, 32'h0);
    endtask

    int          lat;
    logic [31:0] dout;
    logic        err;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        mov_a = 0; rw_a = 0; size_a = 0; addr_a = 0; din_a = 0;
        mov_b = 0; rw_b = 0; size_b = 0; addr_b = 0; din_b = 0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_moc", {31'b0, moc_a}, 32'h0);
        check_val("rst_err", {31'b0, err_a}, 32'h0);
        check_val("rst_dout", dout_a, 32'h0);
        check_val("rst_state", 32'(dut_a.state), 32'(IDLE));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Word write then word read, latency WAIT_STATES+1
        run_op("wr_word", 0, 1'b0, SZ_WORD, 32'h10, 32'hDEADBEEF, lat, dout, err);
        check_val("wr_word_lat", lat, 32'd3);
        run_op("rd_word", 0, 1'b1, SZ_WORD, 32'h10, 32'h0, lat, dout, err);
        check_val("rd_word_lat", lat, 32'd3);
        check_val("rd_word_data", dout, 32'hDEADBEEF);
        run_op("rd_b10", 0, 1'b1, SZ_BYTE, 32'h10, 32'h0, lat, dout, err);
        check_val("rd_b10_data", dout, 32'h000000DE);

        // Byte write over the word; DataOut holds through the write
        run_op("wr_b11", 0, 1'b0, SZ_BYTE, 32'h11, 32'hFFFFFFA5, lat, dout, err);
        check_val("wr_b11_hold", dout_a, 32'h000000DE);
        run_op("rd_word2", 0, 1'b1, SZ_WORD, 32'h10, 32'h0, lat, dout, err);
        check_val("rd_word2_data", dout, 32'hDEA5BEEF);
        run_op("rd_b11", 0, 1'b1, SZ_BYTE, 32'h11, 32'h0, lat, dout, err);
        check_val("rd_b11_data", dout, 32'h000000A5);
        run_op("rd_h12", 0, 1'b1, SZ_HALF, 32'h12, 32'h0, lat, dout, err);
        check_val("rd_h12_data", dout, 32'h0000BEEF);
        run_op("wr_h12", 0, 1'b0, SZ_HALF, 32'h12, 32'hFFFF9876, lat, dout, err);
        run_op("rd_word3", 0, 1'b1, SZ_WORD, 32'h10, 32'h0, lat, dout, err);
        check_val("rd_word3_data", dout, 32'hDEA59876);

        // Abort: MOV dropped during the second WAIT cycle
        run_op("wr_20", 0, 1'b0, SZ_WORD, 32'h20, 32'hCAFEF00D, lat, dout, err);
        mov_a = 1'b1; rw_a = 1'b0; size_a = SZ_WORD; addr_a = 32'h20; din_a = 32'h12345678;
        @(posedge clk); #1;
        check_val("abort_moc0", {31'b0, moc_a}, 32'h0);
        @(posedge clk); #1;
        mov_a = 1'b0;
        @(posedge clk); #1;
        check_val("abort_moc1", {31'b0, moc_a}, 32'h0);
        check_val("abort_state", 32'(dut_a.state), 32'(IDLE));
        @(posedge clk); #1;
        check_val("abort_moc2", {31'b0, moc_a}, 32'h0);
        check_val("abort_dout", dout_a, 32'hDEA59876);
        run_op("rd_20", 0, 1'b1, SZ_WORD, 32'h20, 32'h0, lat, dout, err);
        check_val("abort_mem", dout, 32'hCAFEF00D);

        // Wrap-around / misaligned word at 0xFE
        run_op("pre_fc", 0, 1'b0, SZ_WORD, 32'hFC, 32'hA1A2A3A4, lat, dout, err);
        run_op("pre_00", 0, 1'b0, SZ_WORD, 32'h00, 32'hB1B2B3B4, lat, dout, err);
        run_op("wr_fe", 0, 1'b0, SZ_WORD, 32'hFE, 32'h11223344, lat, dout, err);
`ifdef MEM_ALIGN_CHECK_EN
        check_val("wr_fe_err", {31'b0, err}, 32'h1);
        check_val("wr_fe_dout", dout, 32'h0);
`else
        check_val("wr_fe_err", {31'b0, err}, 32'h0);
`endif
        run_op("rd_fe", 0, 1'b1, SZ_BYTE, 32'hFE, 32'h0, lat, dout, err);
`ifdef MEM_ALIGN_CHECK_EN
        check_val("mem_fe", dout, 32'h000000A3);
`else
        check_val("mem_fe", dout, 32'h00000011);
`endif
        run_op("rd_ff", 0, 1'b1, SZ_BYTE, 32'hFF, 32'h0, lat, dout, err);
`ifdef MEM_ALIGN_CHECK_EN
        check_val("mem_ff", dout, 32'h000000A4);
`else
        check_val("mem_ff", dout, 32'h00000022);
`endif
        run_op("rd_00", 0, 1'b1, SZ_BYTE, 32'h00, 32'h0, lat, dout, err);
`ifdef MEM_ALIGN_CHECK_EN
        check_val("mem_00", dout, 32'h000000B1);
`else
        check_val("mem_00", dout, 32'h00000033);
`endif
        run_op("rd_01", 0, 1'b1, SZ_BYTE, 32'h01, 32'h0, lat, dout, err);
`ifdef MEM_ALIGN_CHECK_EN
        check_val("mem_01", dout, 32'h000000B2);
`else
        check_val("mem_01", dout, 32'h00000044);
`endif
        run_op("rd_wfe", 0, 1'b1, SZ_WORD, 32'hFE, 32'h0, lat, dout, err);
`ifdef MEM_ALIGN_CHECK_EN
        check_val("rd_wfe_err", {31'b0, err}, 32'h1);
        check_val("rd_wfe_data", dout, 32'h0);
`else
        check_val("rd_wfe_err", {31'b0, err}, 32'h0);
        check_val("rd_wfe_data", dout, 32'h11223344);
`endif

        // Reset while in DONE with MOV held, then a fresh transaction
        start_wait(0, 1'b0, SZ_BYTE, 32'h40, 32'h0000003C, lat);
        check_val("rstd_lat", lat, 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rstd_moc", {31'b0, moc_a}, 32'h0);
        check_val("rstd_dout", dout_a, 32'h0);
        check_val("rstd_state", 32'(dut_a.state), 32'(IDLE));
        #1;
        reset_n = 1'b1;
        rw_a = 1'b1;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (moc_a) begin
                lat = n;
                break;
            end
        end
        check_val("rstd_fresh_lat", lat, 32'd3);
        check_val("rstd_fresh_data", dout_a, 32'h0000003C);
        mov_a = 1'b0;
        @(posedge clk); #1;
        check_val("rstd_fresh_moc", {31'b0, moc_a}, 32'h0);

        // Reset during WAIT commits nothing
        mov_a = 1'b1; rw_a = 1'b0; size_a = SZ_BYTE; addr_a = 32'h40; din_a = 32'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        mov_a = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op("rstw_rd", 0, 1'b1, SZ_BYTE, 32'h40, 32'h0, lat, dout, err);
        check_val("rstw_mem", dout, 32'h0000003C);

        // WAIT_STATES=0 instance: latency 1, MOC held, four-phase release
        run_op("b_wr", 1, 1'b0, SZ_WORD, 32'h10, 32'h55AA33CC, lat, dout, err);
        check_val("b_wr_lat", lat, 32'd1);
        mov_b = 1'b1; rw_b = 1'b1; size_b = SZ_WORD; addr_b = 32'h10;
        @(posedge clk); #1;
        check_val("b_rd_moc_k", {31'b0, moc_b}, 32'h0);
        @(posedge clk); #1;
        check_val("b_rd_moc_k1", {31'b0, moc_b}, 32'h1);
        check_val("b_rd_data", dout_b, 32'h55AA33CC);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val($sformatf("b_hold%0d", i), {31'b0, moc_b}, 32'h1);
        end
        mov_b = 1'b0;
        @(posedge clk); #1;
        check_val("b_release", {31'b0, moc_b}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
